addsub_sweep_checker: RTL
=========================

# addsub_sweep_checker

Exhaustive hardware self-checker for the WIDTH-bit ripple adder/subtractor (`cin` = 0 add, `cin` = 1 subtract). On `start` it walks every `{cin, b, a}` combination and drives each onto the DUT. It samples the DUT's combinational `s` and `cout`, compares them against an internal golden model, and reports a pass flag, an error count and the first failing vector. It sits beside the adder/subtractor on the board-level top, on the consuming end of the DUT's result interface, replacing manual switch/LED checking.

## Interface
Parameters:
- WIDTH, 4, operand width of the DUT.
- SETTLE, 1, cycles each vector is held before sampling; must be ≥ 1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begins a sweep; accepted only in IDLE.
- dut_cin  out  1  mode to DUT: 0 add, 1 subtract.
- dut_a  out  WIDTH  operand a to DUT.
- dut_b  out  WIDTH  operand b to DUT.
- dut_s  in  WIDTH  DUT sum/difference.
- dut_cout  in  1  DUT carry out.
- busy  out  1  high while vectors are being applied or checked.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  1 if the last completed sweep had zero mismatches; held until next start.
- err_count  out  2*WIDTH+2  number of mismatching vectors in the current or last sweep.
- first_fail  out  2*WIDTH+1  `{cin, b, a}` of the first mismatch; 0 when err_count = 0.

## Operation
- Vector index `idx`, 2*WIDTH+1 bits; `{dut_cin, dut_b, dut_a} = idx`. a varies fastest, then b, then cin. Order runs 0 to 2^(2*WIDTH+1)−1, so the cin = 0 half precedes the cin = 1 half.
- Golden model (2*WIDTH+1-bit arithmetic, zero-extended):
  - Add: `{cout, s} = a + b`.
  - Subtract: `{cout, s} = a + ~b + 1`; cout = 1 means no borrow, and a−0 gives cout = 1.
- Mismatch: s ≠ expected s, or cout ≠ expected cout, at the sample point.
  - On a mismatch, err_count increments. err_count cannot overflow, since its maximum is 2^(2*WIDTH+1).
  - first_fail captures idx only when err_count = 0 before the increment.
- FSM states: IDLE, APPLY, CHECK, FIN.
  - IDLE: start=1 → APPLY. On that transition idx, err_count, first_fail and pass clear to 0, and vector 0 is driven.
  - APPLY: holds the vector for SETTLE cycles, then → CHECK.
  - CHECK: compares at the closing edge. If idx is last → FIN; otherwise idx+1 is driven and the FSM → APPLY.
  - FIN: done=1, pass ← (err_count = 0), then → IDLE. The dut_* outputs hold the last vector.
- start is ignored in APPLY, CHECK and FIN. A start held high in IDLE after FIN launches a new sweep.
- Reset values (asynchronous, any state): state IDLE; dut_cin, dut_a, dut_b, busy, done, pass, err_count and first_fail all 0. A reset mid-sweep aborts it with no done pulse.

## Timing
- Let edge 0 be the edge sampling start in IDLE.
- busy is 1 from edge 0 until the edge entering FIN; it is 0 during FIN.
- Vector k is driven from edge k·(SETTLE+1) and sampled at edge (k+1)·(SETTLE+1).
- For WIDTH=4, SETTLE=1: 512 vectors × 2 cycles. FIN is entered at edge 1024, and done is high for the cycle between edges 1024 and 1025.
- err_count and first_fail update at the CHECK edge and are visible the next cycle.
- pass is valid from the FIN cycle onward.
- The DUT must be combinational with settle time under SETTLE clock periods.

## Structure
- Package `addsub_chk_pkg`:
  - state enum {IDLE, APPLY, CHECK, FIN};
  - default WIDTH and SETTLE constants;
  - function `addsub_expect(cin, a, b)` returning `{cout, s}`.
- Sub-module `addsub_ref`: combinational golden model wrapping `addsub_expect`, instantiated once. The FSM, counters and capture registers live in `addsub_sweep_checker`.
- A SETTLE counter of width ≥ clog2(SETTLE+1).

## Test plan
- Reset, then start against a correct adder/subtractor (WIDTH=4, SETTLE=1) → done pulses in the cycle after edge 1024; pass=1; err_count=0; first_fail=0.
- Vector order: sample the dut_* outputs after edges 2 and 512 → `{cin,b,a}` = 0_0000_0001 and 1_0000_0000 respectively.
- DUT with s[0] stuck at 0 → err_count=256, first_fail=9'h001, pass=0.
- DUT with cout inverted only when cin=1 → err_count=256, first_fail=9'h100, pass=0.
- Assert rst_n=0 at cycle 300 → all outputs 0 immediately with no done pulse. A subsequent start completes normally with pass=1.
- start pulsed at cycles 10 and 600 and during FIN → all ignored; exactly one done pulse, at edge 1024.

Source files
------------

// File: rtl/addsub_chk_pkg.sv
// addsub_chk_pkg: sweep FSM states, default WIDTH/SETTLE and golden {cout, s} arithmetic for the adder/subtractor checker
package addsub_chk_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_SETTLE = 1;
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, FIN} state_t;
  function automatic logic [32:0] addsub_expect(input logic cin, input logic [31:0] a, input logic [31:0] b, input int w);
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return {1'b0, a} + {1'b0, cin ? (~b & m) : b} + {32'd0, cin};
  endfunction
endpackage

// File: rtl/addsub_ref.sv
// addsub_ref: combinational golden model; ports cin/a/b in, exp_cs = {cout, s} out
module addsub_ref
  import addsub_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   exp_cs
);
  assign exp_cs = (WIDTH+1)'(addsub_expect(cin, 32'(a), 32'(b), WIDTH));
endmodule

// File: rtl/addsub_sweep_checker.sv
// addsub_sweep_checker: exhaustive {cin,b,a} sweep of an adder/subtractor; ports clk/rst_n/start in, dut_cin/a/b out, dut_s/cout in, busy/done/pass/err_count/first_fail out
module addsub_sweep_checker
  import addsub_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 dut_cin,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic [WIDTH-1:0]     dut_s,
  input  logic                 dut_cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     first_fail
);
  localparam int IW = 2*WIDTH+1;
  localparam int CW = $clog2(SETTLE+1);
  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW:0]     err_q, err_d;
  logic [IW-1:0]   ff_q, ff_d;
  logic            pass_q, pass_d;
  logic [WIDTH:0]  exp_cs;
  logic            mism;
  addsub_ref #(.WIDTH(WIDTH)) u_ref (
    .cin   (idx_q[IW-1]),
    .a     (idx_q[WIDTH-1:0]),
    .b     (idx_q[2*WIDTH-1:WIDTH]),
    .exp_cs(exp_cs)
  );
  assign mism = {dut_cout, dut_s} != exp_cs;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ff_d    = ff_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = APPLY;
        idx_d   = '0;
        cnt_d   = '0;
        err_d   = '0;
        ff_d    = '0;
        pass_d  = 1'b0;
      end
      APPLY: begin
        cnt_d   = (cnt_q == CW'(SETTLE-1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(SETTLE-1)) ? CHECK : APPLY;
      end
      CHECK: begin
        err_d   = err_q + (IW+1)'(mism);
        ff_d    = (mism && err_q == '0) ? idx_q : ff_q;
        state_d = (&idx_q) ? FIN : APPLY;
        idx_d   = (&idx_q) ? idx_q : idx_q + 1'b1;
        pass_d  = (&idx_q) ? (err_d == '0) : pass_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ff_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      pass_q  <= pass_d;
    end
  end
  assign {dut_cin, dut_b, dut_a} = idx_q;
  assign busy       = state_q == APPLY || state_q == CHECK;
  assign done       = state_q == FIN;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
endmodule
